regfile_write_sequencer: RTL and testbench



---
 rtl/regfile_write_sequencer.sv | 170 +++++++++++++++++
 tb/tb_regfile_write_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// Dual-commit to single-write-port sequencer. Buffers in-order commits in a FIFO,
// drains one register-file write per cycle and orders a flush behind pending writes.
//
// state | meaning
// RUN   | accepting commits and draining the FIFO
// DRAIN | flush pending; commits blocked until the FIFO has fully drained
// FLUSH | one-cycle flush pulse on the register file
module regfile_write_sequencer #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            c0_valid_in,
  input  logic [4:0]      c0_addr_in,
  input  logic [31:0]     c0_data_in,
  input  logic [2:0]      c0_rob_ix_in,
  input  logic            c1_valid_in,
  input  logic [4:0]      c1_addr_in,
  input  logic [31:0]     c1_data_in,
  input  logic [2:0]      c1_rob_ix_in,
  output logic            commit_ready_out,
  input  logic            flush_req_in,
  input  logic [7:0][4:0] flush_addrs_in,
  output logic            we_out,
  output logic [4:0]      wa_out,
  output logic [31:0]     wd_out,
  output logic [2:0]      rob_ix_out,
  output logic            flush_out,
  output logic [7:0][4:0] flush_addrs_out,
  output logic [CW-1:0]   count_out,
  output logic            busy_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  rob;
  } entry_t;

  state_t             state_q, state_d;
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               we_q, we_d;
  logic [4:0]         wa_q, wa_d;
  logic [31:0]        wd_q, wd_d;
  logic [2:0]         rob_q, rob_d;
  logic               flush_q, flush_d;
  logic [7:0][4:0]    fl_addrs_q, fl_addrs_d;

  logic   commit_ready, push0, push1, push_a, push_b, pop;
  entry_t e0, e1, ent_a, ent_b, head;

  always_comb begin
    commit_ready = !rst_in && (state_q == RUN) && (count_q <= CW'(DEPTH - 2));
    push0 = c0_valid_in && commit_ready && (c0_addr_in != 5'd0);
    push1 = c1_valid_in && commit_ready && (c1_addr_in != 5'd0);
    e0 = '{addr: c0_addr_in, data: c0_data_in, rob: c0_rob_ix_in};
    e1 = '{addr: c1_addr_in, data: c1_data_in, rob: c1_rob_ix_in};
    pop = (count_q != '0);

    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    rob_d      = rob_q;
    flush_d    = 1'b0;
    fl_addrs_d = fl_addrs_q;
    head       = e0;
    push_a     = 1'b0;
    push_b     = 1'b0;
    ent_a      = e0;
    ent_b      = e1;

    // Queued entries always go first; an empty FIFO lets the oldest accepted slot bypass it.
    if (pop) begin
      head     = mem_q[rd_ptr_q];
      we_d     = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(1);
      push_a   = push0;
      push_b   = push1;
    end else if (push0) begin
      head   = e0;
      we_d   = 1'b1;
      push_a = push1;
      ent_a  = e1;
    end else if (push1) begin
      head = e1;
      we_d = 1'b1;
    end

    if (we_d) begin
      wa_d  = head.addr;
      wd_d  = head.data;
      rob_d = head.rob;
    end

    if (push_a) mem_d[wr_ptr_q] = ent_a;
    if (push_b) mem_d[wr_ptr_q + AW'(push_a)] = ent_b;
    wr_ptr_d = wr_ptr_q + AW'(push_a) + AW'(push_b);
    count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);

    case (state_q)
      RUN: begin
        if (flush_req_in) begin
          fl_addrs_d = flush_addrs_in;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        // Last pop already sits on the write port, so the flush lands strictly after it.
        if (count_q == '0) begin
          state_d = FLUSH;
          flush_d = 1'b1;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      rob_q      <= '0;
      flush_q    <= 1'b0;
      fl_addrs_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      rob_q      <= rob_d;
      flush_q    <= flush_d;
      fl_addrs_q <= fl_addrs_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign commit_ready_out = commit_ready;
  assign we_out           = we_q;
  assign wa_out           = wa_q;
  assign wd_out           = wd_q;
  assign rob_ix_out       = rob_q;
  assign flush_out        = flush_q;
  assign flush_addrs_out  = fl_addrs_q;
  assign count_out        = count_q;
  assign busy_out         = (state_q != RUN) || (count_q != '0);

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer: bypass latency, backpressure, x0 drop,
// flush ordering and mid-operation reset.
module tb_regfile_write_sequencer;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            c0_valid_in, c1_valid_in;
  logic [4:0]      c0_addr_in, c1_addr_in;
  logic [31:0]     c0_data_in, c1_data_in;
  logic [2:0]      c0_rob_ix_in, c1_rob_ix_in;
  logic            commit_ready_out;
  logic            flush_req_in;
  logic [7:0][4:0] flush_addrs_in;
  logic            we_out;
  logic [4:0]      wa_out;
  logic [31:0]     wd_out;
  logic [2:0]      rob_ix_out;
  logic            flush_out;
  logic [7:0][4:0] flush_addrs_out;
  logic [3:0]      count_out;
  logic            busy_out;

  regfile_write_sequencer #(.DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .c0_valid_in(c0_valid_in), .c0_addr_in(c0_addr_in), .c0_data_in(c0_data_in),
    .c0_rob_ix_in(c0_rob_ix_in),
    .c1_valid_in(c1_valid_in), .c1_addr_in(c1_addr_in), .c1_data_in(c1_data_in),
    .c1_rob_ix_in(c1_rob_ix_in),
    .commit_ready_out(commit_ready_out),
    .flush_req_in(flush_req_in), .flush_addrs_in(flush_addrs_in),
    .we_out(we_out), .wa_out(wa_out), .wd_out(wd_out), .rob_ix_out(rob_ix_out),
    .flush_out(flush_out), .flush_addrs_out(flush_addrs_out),
    .count_out(count_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  logic [39:0] wlog[$];
  int          n_flush   = 0;
  int          flush_at  = 0;
  int          n_overlap = 0;

  // Observed register-file traffic, sampled on the edge that ends each cycle.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      if (we_out) wlog.push_back({wa_out, wd_out, rob_ix_out});
      if (flush_out) begin
        n_flush  = n_flush + 1;
        flush_at = wlog.size();
      end
      if (we_out && flush_out) n_overlap = n_overlap + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    c0_valid_in  = 1'b0;
    c1_valid_in  = 1'b0;
    flush_req_in = 1'b0;
  endtask

  task automatic drive(input logic [4:0] a0, input logic [31:0] d0, input logic [2:0] r0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic [2:0] r1);
    c0_valid_in = 1'b1; c0_addr_in = a0; c0_data_in = d0; c0_rob_ix_in = r0;
    c1_valid_in = 1'b1; c1_addr_in = a1; c1_data_in = d1; c1_rob_ix_in = r1;
  endtask

  function automatic logic [39:0] mk(input logic [4:0] a, input logic [31:0] d, input logic [2:0] r);
    return {a, d, r};
  endfunction

  initial begin
    logic [7:0][4:0] exp_fa;
    logic [7:0][4:0] junk_fa;
    int wbase, fbase, k, cycles, stalls, n;

    for (int i = 0; i < 8; i++) begin
      exp_fa[i]  = 5'(i + 1);
      junk_fa[i] = 5'd31;
    end
    rst_in = 1'b1;
    idle();
    c0_addr_in = '0; c0_data_in = '0; c0_rob_ix_in = '0;
    c1_addr_in = '0; c1_data_in = '0; c1_rob_ix_in = '0;
    flush_addrs_in = '0;
    tick();
    tick();

    // reset state
    check("rst_we", we_out, 0);
    check("rst_count", count_out, 0);
    check("rst_flush", flush_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_ready", commit_ready_out, 0);
    check("rst_fa", flush_addrs_out, 0);
    rst_in = 1'b0;
    #1;
    check("run_ready", commit_ready_out, 1);

    // single commit bypasses the empty FIFO
    drive(5'd5, 32'hDEADBEEF, 3'd3, 5'd0, 32'h0, 3'd0);
    c1_valid_in = 1'b0;
    tick();
    idle();
    check("t1_we", we_out, 1);
    check("t1_wa", wa_out, 5);
    check("t1_wd", wd_out, 32'hDEADBEEF);
    check("t1_rob", rob_ix_out, 3);
    check("t1_count", count_out, 0);
    tick();
    check("t1_we_low", we_out, 0);
    check("t1_wd_hold", wd_out, 32'hDEADBEEF);
    tick();

    // sustained dual commit with backpressure
    wbase = wlog.size();
    k = 0; cycles = 0; stalls = 0;
    while (k < 8 && cycles < 40) begin
      drive(5'd1, 32'h11 | (32'(k) << 16), 3'd0, 5'd2, 32'h22 | (32'(k) << 16), 3'd1);
      n = int'(commit_ready_out);
      tick();
      if (n == 1) k++;
      else stalls++;
      cycles++;
    end
    idle();
    check("t2_cycles", cycles, 9);
    check("t2_stalls", stalls, 1);
    check("t2_count_full", count_out, 7);
    check("t2_ready_low", commit_ready_out, 0);
    n = 0;
    while (busy_out && n < 30) begin
      tick();
      n++;
    end
    check("t2_drained", busy_out, 0);
    tick();
    tick();
    check("t2_nwrites", wlog.size() - wbase, 16);
    for (int i = 0; i < 16 && (wbase + i) < wlog.size(); i++) begin
      if (i % 2 == 0) check("t2_wr_even", wlog[wbase + i], mk(5'd1, 32'h11 | (32'(i / 2) << 16), 3'd0));
      else            check("t2_wr_odd", wlog[wbase + i], mk(5'd2, 32'h22 | (32'(i / 2) << 16), 3'd1));
    end

    // x0 commit is accepted but produces no write
    wbase = wlog.size();
    drive(5'd3, 32'h33, 3'd2, 5'd4, 32'h44, 3'd3);
    tick();
    check("t3_count_a", count_out, 1);
    drive(5'd0, 32'h99, 3'd4, 5'd7, 32'h77, 3'd5);
    tick();
    idle();
    check("t3_count_b", count_out, 1);
    check("t3_wa_r4", wa_out, 4);
    tick();
    check("t3_wa_r7", wa_out, 7);
    check("t3_count_c", count_out, 0);
    tick();
    tick();
    check("t3_nwrites", wlog.size() - wbase, 3);
    if (wlog.size() - wbase >= 3) begin
      check("t3_wr0", wlog[wbase],     mk(5'd3, 32'h33, 3'd2));
      check("t3_wr1", wlog[wbase + 1], mk(5'd4, 32'h44, 3'd3));
      check("t3_wr2", wlog[wbase + 2], mk(5'd7, 32'h77, 3'd5));
    end

    // flush waits for three queued writes; a second request is absorbed
    wbase = wlog.size();
    fbase = n_flush;
    drive(5'd10, 32'hA0, 3'd0, 5'd11, 32'hB1, 3'd1);
    tick();
    drive(5'd12, 32'hC2, 3'd2, 5'd13, 32'hD3, 3'd3);
    tick();
    drive(5'd14, 32'hE4, 3'd4, 5'd15, 32'hF5, 3'd5);
    flush_req_in = 1'b1;
    flush_addrs_in = exp_fa;
    tick();
    check("t4_ready_drain", commit_ready_out, 0);
    check("t4_count3", count_out, 3);
    drive(5'd20, 32'h200, 3'd6, 5'd21, 32'h210, 3'd7);
    flush_req_in = 1'b1;
    flush_addrs_in = junk_fa;
    tick();
    idle();
    flush_addrs_in = '0;
    check("t4_count2", count_out, 2);
    n = 0;
    while (!flush_out && n < 20) begin
      tick();
      n++;
    end
    check("t4_flush_delay", n, 3);
    check("t4_flush", flush_out, 1);
    check("t4_flush_we", we_out, 0);
    check("t4_flush_fa", flush_addrs_out, exp_fa);
    check("t4_ready_flush", commit_ready_out, 0);
    tick();
    check("t4_flush_end", flush_out, 0);
    check("t4_ready_run", commit_ready_out, 1);
    check("t4_busy", busy_out, 0);
    tick();
    tick();
    tick();
    check("t4_npulses", n_flush - fbase, 1);
    check("t4_nwrites", wlog.size() - wbase, 6);
    check("t4_flush_after", flush_at - wbase, 6);
    if (wlog.size() - wbase >= 6) begin
      check("t4_wr0", wlog[wbase],     mk(5'd10, 32'hA0, 3'd0));
      check("t4_wr3", wlog[wbase + 3], mk(5'd13, 32'hD3, 3'd3));
      check("t4_wr5", wlog[wbase + 5], mk(5'd15, 32'hF5, 3'd5));
    end

    // reset with five queued entries and a pending flush
    for (int i = 0; i < 4; i++) begin
      drive(5'd8, 32'h80 + 32'(i), 3'd0, 5'd9, 32'h90 + 32'(i), 3'd1);
      tick();
    end
    drive(5'd8, 32'h84, 3'd0, 5'd9, 32'h94, 3'd1);
    flush_req_in = 1'b1;
    flush_addrs_in = exp_fa;
    tick();
    idle();
    check("t5_count5", count_out, 5);
    rst_in = 1'b1;
    tick();
    check("t5_we", we_out, 0);
    check("t5_count", count_out, 0);
    check("t5_flush", flush_out, 0);
    check("t5_busy", busy_out, 0);
    check("t5_wd", wd_out, 0);
    check("t5_fa", flush_addrs_out, 0);
    rst_in = 1'b0;
    wbase = wlog.size();
    fbase = n_flush;
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_writes", wlog.size() - wbase, 0);
    check("t5_no_flush", n_flush - fbase, 0);
    check("t5_count_after", count_out, 0);
    check("t5_ready", commit_ready_out, 1);
    check("overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
